// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match sequencer.
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam int H_LAST  = 639;
    localparam int V_LAST  = 479;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/pong_match_ctrl_rise_detect.sv
// Rising-edge detector; the history flop resets high so a level held through reset is not an event.
module rise_detect (
    input  logic clk,
    input  logic rst_b,
    input  logic sig,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_b) prev <= 1'b1;
        else        prev <= sig;
    end

    assign rise = sig & ~prev;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, play, point hold, pause and game-over,
// driving the ball engine enable/recentre and keeping per-player scores.
//
// state | meaning
// IDLE  | waiting for start, ball held centred
// SERVE | counting SERVE_FRAMES frames before play
// PLAY  | ball engine running, point flags scored
// POINT | field frozen for POINT_FRAMES frames after a point
// PAUSE | ball frozen in place until the next pause press
// OVER  | match decided, winner shown until start
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic               clk_in,
    input  logic               i_rst,
    input  logic               frame_end,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               pointPlayer1,
    input  logic               pointPlayer2,
    output logic               enablePong,
    output logic               ball_rst,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic [2:0]         state_dbg
);

    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int FW         = ($clog2(MAX_FRAMES) < 1) ? 1 : $clog2(MAX_FRAMES);
    localparam logic [FW-1:0]      SERVE_LAST = FW'(SERVE_FRAMES - 1);
    localparam logic [FW-1:0]      POINT_LAST = FW'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    logic start_e, pause_e, p1_e, p2_e;

    rise_detect u_rd_start (.clk(clk_in), .rst_b(i_rst), .sig(btn_start),    .rise(start_e));
    rise_detect u_rd_pause (.clk(clk_in), .rst_b(i_rst), .sig(btn_pause),    .rise(pause_e));
    rise_detect u_rd_p1    (.clk(clk_in), .rst_b(i_rst), .sig(pointPlayer1), .rise(p1_e));
    rise_detect u_rd_p2    (.clk(clk_in), .rst_b(i_rst), .sig(pointPlayer2), .rise(p2_e));

    state_t              state, nxt;
    logic [FW-1:0]       fcnt, fcnt_nxt;
    logic [SCORE_W-1:0]  s1_nxt, s2_nxt;
    logic [1:0]          win_nxt;

    always_comb begin
        nxt      = state;
        fcnt_nxt = fcnt;
        s1_nxt   = score1;
        s2_nxt   = score2;
        win_nxt  = winner;
        case (state)
            ST_IDLE: begin
                if (start_e) begin
                    s1_nxt = '0;
                    s2_nxt = '0;
                    nxt    = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (frame_end) begin
                    if (fcnt == SERVE_LAST) nxt = ST_PLAY;
                    else                    fcnt_nxt = fcnt + FW'(1);
                end
            end
            ST_PLAY: begin
                // simultaneous point edges are a replay: freeze without scoring
                if (p1_e || p2_e) begin
                    nxt = ST_POINT;
                    if (p1_e && !p2_e) s1_nxt = sat_inc(score1);
                    if (p2_e && !p1_e) s2_nxt = sat_inc(score2);
                end else if (pause_e) begin
                    nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_e) nxt = ST_PLAY;
            end
            ST_POINT: begin
                if (frame_end) begin
                    if (fcnt == POINT_LAST) begin
                        if (score1 >= WIN_VAL || score2 >= WIN_VAL) begin
                            nxt     = ST_OVER;
                            win_nxt = (score1 >= WIN_VAL) ? WIN_P1 : WIN_P2;
                        end else begin
                            nxt = ST_SERVE;
                        end
                    end else begin
                        fcnt_nxt = fcnt + FW'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start_e) begin
                    s1_nxt  = '0;
                    s2_nxt  = '0;
                    win_nxt = WIN_NONE;
                    nxt     = ST_SERVE;
                end
            end
            default: nxt = ST_IDLE;
        endcase
        if (nxt != state) fcnt_nxt = '0;
    end

    always_ff @(posedge clk_in) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            fcnt       <= '0;
            score1     <= '0;
            score2     <= '0;
            winner     <= WIN_NONE;
            enablePong <= 1'b0;
            ball_rst   <= 1'b1;
        end else begin
            state      <= nxt;
            fcnt       <= fcnt_nxt;
            score1     <= s1_nxt;
            score2     <= s2_nxt;
            winner     <= win_nxt;
            enablePong <= (nxt == ST_PLAY);
            ball_rst   <= !(nxt == ST_PLAY || nxt == ST_PAUSE);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with a frame-countdown reference model checked every cycle.
module tb_pong_match_ctrl;
    import pong_pkg::*;

    localparam int WIN   = 3;
    localparam int SERVE = 60;
    localparam int POINT = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fe = 1'b0, start = 1'b0, pause = 1'b0, p1 = 1'b0, p2 = 1'b0;
    logic       en, brst;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SERVE), .POINT_FRAMES(POINT)) dut (
        .clk_in(clk), .i_rst(rst), .frame_end(fe), .btn_start(start), .btn_pause(pause),
        .pointPlayer1(p1), .pointPlayer2(p2), .enablePong(en), .ball_rst(brst),
        .score1(score1), .score2(score2), .winner(winner), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // reference model: remaining-frame countdown, integer scores
    state_t m_st;
    int     m_left, m_s1, m_s2, m_w;
    logic   pv_start, pv_pause, pv_p1, pv_p2;
    wire    e_start = start & ~pv_start;
    wire    e_pause = pause & ~pv_pause;
    wire    e_p1    = p1 & ~pv_p1;
    wire    e_p2    = p2 & ~pv_p2;

    always @(posedge clk) begin
        if (!rst) begin
            m_st <= ST_IDLE; m_left <= 0; m_s1 <= 0; m_s2 <= 0; m_w <= 0;
            pv_start <= 1'b1; pv_pause <= 1'b1; pv_p1 <= 1'b1; pv_p2 <= 1'b1;
        end else begin
            pv_start <= start; pv_pause <= pause; pv_p1 <= p1; pv_p2 <= p2;
            case (m_st)
                ST_IDLE, ST_OVER:
                    if (e_start) begin
                        m_s1 <= 0; m_s2 <= 0; m_w <= 0;
                        m_st <= ST_SERVE; m_left <= SERVE;
                    end
                ST_SERVE:
                    if (fe) begin
                        if (m_left == 1) m_st <= ST_PLAY;
                        else m_left <= m_left - 1;
                    end
                ST_PLAY:
                    if (e_p1 || e_p2) begin
                        m_st <= ST_POINT; m_left <= POINT;
                        if (e_p1 && !e_p2) m_s1 <= (m_s1 >= 15) ? 15 : m_s1 + 1;
                        if (e_p2 && !e_p1) m_s2 <= (m_s2 >= 15) ? 15 : m_s2 + 1;
                    end else if (e_pause) m_st <= ST_PAUSE;
                ST_PAUSE:
                    if (e_pause) m_st <= ST_PLAY;
                ST_POINT:
                    if (fe) begin
                        if (m_left == 1) begin
                            if (m_s1 >= WIN || m_s2 >= WIN) begin
                                m_st <= ST_OVER; m_w <= (m_s1 >= WIN) ? 1 : 2;
                            end else begin
                                m_st <= ST_SERVE; m_left <= SERVE;
                            end
                        end else m_left <= m_left - 1;
                    end
                default: m_st <= ST_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("state",  int'(state_dbg), int'(m_st));
            check("enable", int'(en),        (m_st == ST_PLAY) ? 1 : 0);
            check("ballrst", int'(brst),     (m_st == ST_PLAY || m_st == ST_PAUSE) ? 0 : 1);
            check("score1", int'(score1),    m_s1);
            check("score2", int'(score2),    m_s2);
            check("winner", int'(winner),    m_w);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            fe = 1'b1; tick(1);
            fe = 1'b0; tick(3);
        end
    endtask

    initial begin
        start = 1'b1;
        tick(1);
        chk_on = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(3);
        check("lit_idle_held_state", int'(state_dbg), 0);
        check("lit_idle_held_brst", int'(brst), 1);

        start = 1'b0; tick(2);
        start = 1'b1; tick(1);
        check("lit_start_serve", int'(state_dbg), 1);
        start = 1'b0;
        frames(SERVE - 1);
        check("lit_serve_59_en", int'(en), 0);
        frames(1);
        check("lit_serve_60_en", int'(en), 1);

        p2 = 1'b1; tick(1);
        check("lit_p2_score2", int'(score2), 1);
        check("lit_p2_en", int'(en), 0);
        tick(2); p2 = 1'b0;
        frames(POINT);
        check("lit_point_to_serve", int'(state_dbg), 1);
        check("lit_point_score1", int'(score1), 0);

        pause = 1'b1; tick(2); pause = 1'b0;
        frames(SERVE);

        p1 = 1'b1; p2 = 1'b1; tick(1);
        check("lit_replay_state", int'(state_dbg), 3);
        check("lit_replay_s1", int'(score1), 0);
        tick(2); p1 = 1'b0; p2 = 1'b0;
        frames(POINT);
        frames(SERVE);

        pause = 1'b1; tick(1);
        check("lit_pause_en", int'(en), 0);
        check("lit_pause_brst", int'(brst), 0);
        tick(1); pause = 1'b0;
        frames(100);
        check("lit_pause_hold", int'(state_dbg), 4);
        pause = 1'b1; tick(1);
        check("lit_resume", int'(state_dbg), 2);
        pause = 1'b0; tick(2);

        pause = 1'b1; fe = 1'b1; tick(1); fe = 1'b0;
        check("lit_pause_with_frame", int'(state_dbg), 4);
        pause = 1'b0; tick(2);
        pause = 1'b1; tick(1); pause = 1'b0; tick(2);

        p1 = 1'b1; pause = 1'b1; tick(1);
        check("lit_point_over_pause", int'(state_dbg), 3);
        check("lit_point_over_pause_s1", int'(score1), 1);
        p1 = 1'b0; pause = 1'b0;
        frames(POINT); frames(SERVE);
        p1 = 1'b1; tick(2); p1 = 1'b0;
        frames(POINT); frames(SERVE);
        check("lit_s1_two", int'(score1), 2);

        rst = 1'b0; tick(1);
        check("lit_rst_state", int'(state_dbg), 0);
        check("lit_rst_s1", int'(score1), 0);
        check("lit_rst_en", int'(en), 0);
        check("lit_rst_brst", int'(brst), 1);
        rst = 1'b1; tick(2);

        start = 1'b1; tick(1); start = 1'b0;
        frames(SERVE);
        for (int k = 0; k < WIN; k++) begin
            p1 = 1'b1; tick(2); p1 = 1'b0;
            frames(POINT);
            if (k < WIN - 1) frames(SERVE);
        end
        check("lit_over_state", int'(state_dbg), 5);
        check("lit_over_winner", int'(winner), 1);
        pause = 1'b1; tick(2); pause = 1'b0; tick(2);
        start = 1'b1; tick(1); start = 1'b0;
        check("lit_restart_state", int'(state_dbg), 1);
        check("lit_restart_winner", int'(winner), 0);
        check("lit_restart_s1", int'(score1), 0);
        tick(4);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
